// File: rtl/dct_sum_sched_if.sv
// Row-input / issue / result-tag signal bundle for the DCT summation sequencer.
interface dct_sum_sched_if;
  logic       row_valid;
  logic       row_sof;
  logic       row_ready;
  logic       row_load;
  logic       hold;
  logic       issue;
  logic [2:0] coef_idx;
  logic       res_valid;
  logic [2:0] res_row;
  logic [2:0] res_col;
  logic       res_blk_last;
  logic       err_sof;
  logic       busy;

  modport slave (
    input  row_valid, row_sof, hold,
    output row_ready, row_load, issue, coef_idx,
           res_valid, res_row, res_col, res_blk_last, err_sof, busy
  );

  modport master (
    output row_valid, row_sof, hold,
    input  row_ready, row_load, issue, coef_idx,
           res_valid, res_row, res_col, res_blk_last, err_sof, busy
  );
endinterface

// File: rtl/dct_sum_sched.sv
// Sequences coefficient issue for the 8-term DCT adder and tags each adder
// output with its row/column/block-end position.
module dct_sum_sched #(
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned ROWS    = 8
) (
  input logic             clk,
  input logic             rst,
  dct_sum_sched_if.slave  bus
);

  localparam int unsigned KW    = 3;
  localparam int unsigned RW    = $clog2(ROWS);
  localparam int unsigned DEPTH = MUL_LAT + 1;
  localparam logic [KW-1:0] K_MAX = '1;
  localparam logic [RW-1:0] R_MAX = RW'(ROWS - 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [KW-1:0] col;
    logic          last;
  } tag_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q;
  logic [RW-1:0]        r_q;
  logic [RW-1:0]        r_adv;
  logic                 err_q;
  logic                 issue;
  logic                 row_ready;
  logic                 k_last;
  logic                 row_end;
  logic                 sof_acc;
  tag_t                 tag_in;
  tag_t [DEPTH-1:0]     pipe_q;
  logic [DEPTH-1:0]     vld_q;

  assign k_last  = (k_q == K_MAX);
  assign row_end = issue & k_last;
  assign sof_acc = bus.row_valid & row_ready & bus.row_sof;
  // Row index the next accepted row would get before any sof override.
  assign r_adv   = row_end ? r_q + RW'(1) : r_q;

  // Next-state and issue/accept decode; hold freezes issue and acceptance.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    row_ready = 1'b0;
    case (state_q)
      IDLE: begin
        row_ready = !bus.hold;
        if (row_ready && bus.row_valid) state_d = ISSUE;
      end
      ISSUE: begin
        if (!bus.hold) begin
          issue = 1'b1;
          if (k_last) begin
            row_ready = 1'b1;
            if (!bus.row_valid) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) k_q <= k_q + KW'(1);
      r_q     <= sof_acc ? '0 : r_adv;
      err_q   <= sof_acc && (r_adv != '0);
    end
  end

  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.row  = r_q;
      tag_in.col  = k_q;
      tag_in.last = (r_q == R_MAX) && k_last;
    end
  end

  // Tag pipeline tracks the multiplier plus adder register; never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
      vld_q  <= '0;
    end else begin
      pipe_q <= {pipe_q[DEPTH-2:0], tag_in};
      vld_q  <= {vld_q[DEPTH-2:0], issue};
    end
  end

  assign bus.row_ready    = row_ready;
  assign bus.row_load     = bus.row_valid & row_ready;
  assign bus.issue        = issue;
  assign bus.coef_idx     = k_q;
  assign bus.err_sof      = err_q;
  assign bus.res_valid    = vld_q[DEPTH-1];
  assign bus.res_row      = pipe_q[DEPTH-1].row;
  assign bus.res_col      = pipe_q[DEPTH-1].col;
  assign bus.res_blk_last = pipe_q[DEPTH-1].last;
  assign bus.busy         = (state_q != IDLE) | (|vld_q);

endmodule

// File: tb/tb_dct_sum_sched.sv
// Bench for dct_sum_sched: MUL_LAT=1 and MUL_LAT=3 instances share stimulus,
// a cycle model predicts control outputs and queues expected result tags.
module tb_dct_sum_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rv  = 1'b0;
  logic sof = 1'b0;
  logic hold = 1'b0;

  always #5 clk = ~clk;

  dct_sum_sched_if bus1 ();
  dct_sum_sched_if bus3 ();

  assign bus1.row_valid = rv;
  assign bus1.row_sof   = sof;
  assign bus1.hold      = hold;
  assign bus3.row_valid = rv;
  assign bus3.row_sof   = sof;
  assign bus3.hold      = hold;

  dct_sum_sched #(.MUL_LAT(1), .ROWS(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dct_sum_sched #(.MUL_LAT(3), .ROWS(8)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    int due;
    int row;
    int col;
    bit last;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_res1 = 0, n_res3 = 0, n_last1 = 0, n_last3 = 0, n_err = 0;

  // Reference state of the scheduler.
  bit m_act = 1'b0;
  bit m_err = 1'b0;
  int m_k   = 0;
  int m_r   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    bit   er, ei, acc, row_end, n_act, n_err_b;
    int   nr, nk;
    exp_t e;

    er  = !hold && (!m_act || m_k == 7);
    ei  = m_act && !hold;
    acc = rv && er;

    chk("row_ready", bus1.row_ready, er);
    chk("row_load",  bus1.row_load,  acc);
    chk("issue",     bus1.issue,     ei);
    chk("coef_idx",  bus1.coef_idx,  m_k);
    chk("err_sof",   bus1.err_sof,   m_err);
    chk("busy",      bus1.busy,      m_act || (q1.size() > 0));
    chk("l3_row_ready", bus3.row_ready, er);
    chk("l3_issue",     bus3.issue,     ei);
    chk("l3_coef_idx",  bus3.coef_idx,  m_k);
    chk("l3_err_sof",   bus3.err_sof,   m_err);
    chk("l3_busy",      bus3.busy,      m_act || (q3.size() > 0));

    if (bus1.res_valid) n_res1++;
    if (bus3.res_valid) n_res3++;
    if (bus1.res_valid && bus1.res_blk_last) n_last1++;
    if (bus3.res_valid && bus3.res_blk_last) n_last3++;
    if (bus1.err_sof) n_err++;

    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      chk("res_valid", bus1.res_valid,    1);
      chk("res_row",   bus1.res_row,      e.row);
      chk("res_col",   bus1.res_col,      e.col);
      chk("res_last",  bus1.res_blk_last, e.last);
    end else begin
      chk("res_idle", bus1.res_valid, 0);
    end

    if (q3.size() > 0 && q3[0].due == cyc) begin
      e = q3.pop_front();
      chk("l3_res_valid", bus3.res_valid,    1);
      chk("l3_res_row",   bus3.res_row,      e.row);
      chk("l3_res_col",   bus3.res_col,      e.col);
      chk("l3_res_last",  bus3.res_blk_last, e.last);
    end else begin
      chk("l3_res_idle", bus3.res_valid, 0);
    end

    if (ei) begin
      e.row  = m_r;
      e.col  = m_k;
      e.last = (m_r == 7) && (m_k == 7);
      e.due  = cyc + 2;
      q1.push_back(e);
      e.due  = cyc + 4;
      q3.push_back(e);
    end

    row_end = ei && (m_k == 7);
    nr      = row_end ? (m_r + 1) % 8 : m_r;
    n_err_b = acc && sof && (nr != 0);
    if (acc && sof) nr = 0;
    n_act   = m_act ? (row_end ? acc : 1'b1) : acc;
    nk      = ei ? (m_k + 1) % 8 : m_k;

    if (rst) begin
      m_act = 1'b0; m_err = 1'b0; m_k = 0; m_r = 0;
      q1.delete();
      q3.delete();
    end else begin
      m_act = n_act; m_err = n_err_b; m_k = nk; m_r = nr;
    end
    cyc++;
  end

  initial begin
    int b1, b3, bl1, bl3, be;

    tick(3);
    rst = 1'b0;
    tick(2);

    // Single row with sof.
    b1 = n_res1; b3 = n_res3;
    rv = 1'b1; sof = 1'b1; tick(1);
    rv = 1'b0; sof = 1'b0; tick(16);
    chk("t1_nres1", n_res1 - b1, 8);
    chk("t1_nres3", n_res3 - b3, 8);

    // Full block back-to-back.
    b1 = n_res1; b3 = n_res3; bl1 = n_last1; bl3 = n_last3;
    rv = 1'b1; sof = 1'b1; tick(1);
    sof = 1'b0; tick(56);
    rv = 1'b0; tick(20);
    chk("t2_nres1",  n_res1 - b1, 64);
    chk("t2_nres3",  n_res3 - b3, 64);
    chk("t2_nlast1", n_last1 - bl1, 1);
    chk("t2_nlast3", n_last3 - bl3, 1);

    // Hold for 3 cycles at k=4.
    b1 = n_res1;
    rv = 1'b1; tick(1);
    rv = 1'b0; tick(4);
    hold = 1'b1; tick(3);
    hold = 1'b0; tick(20);
    chk("t3_nres1", n_res1 - b1, 8);

    // Hold at the k=7 cycle with a row pending.
    b1 = n_res1;
    rv = 1'b1; tick(1);
    tick(7);
    hold = 1'b1; tick(2);
    hold = 1'b0; tick(1);
    rv = 1'b0; tick(20);
    chk("t3b_nres1", n_res1 - b1, 16);

    // Reset at the k=5 issue cycle drops in-flight results.
    b1 = n_res1; b3 = n_res3;
    rv = 1'b1; sof = 1'b1; tick(1);
    rv = 1'b0; sof = 1'b0; tick(5);
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(12);
    chk("t5_nres1", n_res1 - b1, 4);
    chk("t5_nres3", n_res3 - b3, 2);

    // sof on the fourth row of a block.
    b1 = n_res1; be = n_err;
    rv = 1'b1; sof = 1'b1; tick(1);
    sof = 1'b0; tick(23);
    sof = 1'b1; tick(1);
    sof = 1'b0; tick(7);
    tick(1);
    rv = 1'b0; tick(20);
    chk("t4_nerr",  n_err - be, 1);
    chk("t4_nres1", n_res1 - b1, 40);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rv   = ($urandom_range(0, 3) != 0);
      sof  = ($urandom_range(0, 7) == 0);
      hold = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    rv = 1'b0; sof = 1'b0; hold = 1'b0; rst = 1'b0;
    tick(30);
    chk("end_q1_empty", q1.size(), 0);
    chk("end_q3_empty", q3.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
